// File: rtl/key_pkg.sv
// Shared types and constants for the key conditioner and its per-button channels.
package key_pkg;

   // Per-channel press/repeat FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      REPEAT = 2'd2
   } key_state_e;

   // Bit positions of each button in the held vector and internal buses.
   localparam int KEY_UP    = 3;
   localparam int KEY_RIGHT = 2;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_LEFT  = 0;
   localparam int NUM_KEYS  = 4;

endpackage

// File: rtl/key_channel.sv
// One button: two-flop synchronizer, debounce filter, and press/auto-repeat FSM
// producing single-cycle strobes. Next-state values of the stable level and the
// strobe are exported so the top can register held/any_key on the same edge.
module key_channel
   import key_pkg::*;
#(
   parameter int DB_CYCLES     = 1_000_000,
   parameter bit REPEAT_EN     = 1'b1,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic st_d,
   output logic strobe_d,
   output logic strobe_q
);

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int DW      = $clog2(DB_CYCLES) + 1;
   localparam int RW      = $clog2(RPT_MAX) + 1;

   localparam logic [DW-1:0] DB_LAST     = DW'(DB_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic [1:0]    sync_d, sync_q;
   logic          s;
   logic [DW-1:0] dcnt_d, dcnt_q;
   logic          st_q;
   logic [RW-1:0] rcnt_d, rcnt_q;
   logic          rise, fall;
   key_state_e    state_d, state_q;

   assign s = sync_q[1];

   // Debounce: count consecutive cycles where s disagrees with st; accept after DB_CYCLES.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      dcnt_d = dcnt_q;
      st_d   = st_q;
      rise   = 1'b0;
      fall   = 1'b0;
      sync_d = {sync_q[0], key_raw};
      if (s == st_q) begin
         dcnt_d = '0;
      end else if (dcnt_q == DB_LAST) begin
         st_d   = s;
         dcnt_d = '0;
         rise   = s;
         fall   = ~s;
      end else begin
         dcnt_d = dcnt_q + 1'b1;
      end
   end

   // FSM next state: a release (fall) always wins over a repeat falling due.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rise) state_d = WAIT;
         WAIT: begin
            if (fall)                                   state_d = IDLE;
            else if (REPEAT_EN && (rcnt_q == DELAY_LAST)) state_d = REPEAT;
         end
         REPEAT:  if (fall) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: strobe on press, after the initial delay, then every period.
   always_comb begin
      rcnt_d   = rcnt_q;
      strobe_d = 1'b0;
      case (state_q)
         IDLE: begin
            rcnt_d   = '0;
            strobe_d = rise;
         end
         WAIT: begin
            if (fall) begin
               rcnt_d = '0;
            end else if (REPEAT_EN) begin
               if (rcnt_q == DELAY_LAST) begin
                  strobe_d = 1'b1;
                  rcnt_d   = '0;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
         end
         REPEAT: begin
            if (fall) begin
               rcnt_d = '0;
            end else if (rcnt_q == PERIOD_LAST) begin
               strobe_d = 1'b1;
               rcnt_d   = '0;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         default: rcnt_d = '0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath registers: synchronizer, debounce counter, stable level, repeat counter, strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking so every flop samples the values from before this edge.
      if (!rst_n) begin
         sync_q   <= '0;
         dcnt_q   <= '0;
         st_q     <= 1'b0;
         rcnt_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         dcnt_q   <= dcnt_d;
         st_q     <= st_d;
         rcnt_q   <= rcnt_d;
         strobe_q <= strobe_d;
      end
   end

endmodule

// File: rtl/key_conditioner.sv
// Four independent button channels feeding U/R/D/L strobes, plus the debounced
// held levels and an any_key strobe registered on the same edge as the strobes.
module key_conditioner
   import key_pkg::*;
#(
   parameter int DB_CYCLES     = 1_000_000,
   parameter bit REPEAT_EN     = 1'b1,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       up,
   input  logic       right,
   input  logic       down,
   input  logic       left,
   output logic       U,
   output logic       R,
   output logic       D,
   output logic       L,
   output logic [3:0] held,
   output logic       any_key
);

   logic [NUM_KEYS-1:0] raw;
   logic [NUM_KEYS-1:0] st_d;
   logic [NUM_KEYS-1:0] strobe_d;
   logic [NUM_KEYS-1:0] strobe_q;
   logic [NUM_KEYS-1:0] held_d, held_q;
   logic                any_key_d, any_key_q;

   assign raw[KEY_UP]    = up;
   assign raw[KEY_RIGHT] = right;
   assign raw[KEY_DOWN]  = down;
   assign raw[KEY_LEFT]  = left;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_channel #(
         .DB_CYCLES     (DB_CYCLES),
         .REPEAT_EN     (REPEAT_EN),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk      (clk),
         .rst_n    (clr),
         .key_raw  (raw[i]),
         .st_d     (st_d[i]),
         .strobe_d (strobe_d[i]),
         .strobe_q (strobe_q[i])
      );
   end

   // Held levels and any_key are taken from the channels' next values so they align with the strobes.
   always_comb begin
      held_d    = st_d;
      any_key_d = |strobe_d;
   end

   // Output registers for held and any_key.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         held_q    <= '0;
         any_key_q <= 1'b0;
      end else begin
         held_q    <= held_d;
         any_key_q <= any_key_d;
      end
   end

   assign U       = strobe_q[KEY_UP];
   assign R       = strobe_q[KEY_RIGHT];
   assign D       = strobe_q[KEY_DOWN];
   assign L       = strobe_q[KEY_LEFT];
   assign held    = held_q;
   assign any_key = any_key_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: two instances (auto-repeat on / off) driven by the same
// buttons, a behavioural model checked every cycle, and hand-computed scenario checks.
module tb_key_conditioner;
   import key_pkg::*;

   localparam int DB  = 4;
   localparam int DLY = 10;
   localparam int PER = 3;

   logic clk = 1'b0;
   logic clr = 1'b0;
   logic up = 1'b0, right = 1'b0, down = 1'b0, left = 1'b0;
   wire  [3:0] keys = {up, right, down, left};

   wire [3:0] str_a, held_a, str_b, held_b;
   wire       any_a, any_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_conditioner #(.DB_CYCLES(DB), .REPEAT_EN(1'b1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_a (
      .clk(clk), .clr(clr), .up(up), .right(right), .down(down), .left(left),
      .U(str_a[3]), .R(str_a[2]), .D(str_a[1]), .L(str_a[0]), .held(held_a), .any_key(any_a));

   key_conditioner #(.DB_CYCLES(DB), .REPEAT_EN(1'b0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_b (
      .clk(clk), .clr(clr), .up(up), .right(right), .down(down), .left(left),
      .U(str_b[3]), .R(str_b[2]), .D(str_b[1]), .L(str_b[0]), .held(held_b), .any_key(any_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // hist[0] = raw sampled at the previous edge, hist[1] = the synchronized level s now.
   // The stable level follows s once s has shown the same value for DB edges in a row.
   // After a press, strobes fall at age DLY and every PER after, while the key stays down.
   typedef struct packed {
      logic [7:0] hist;
      logic       st;
      int         age;
      logic       strobe;
   } mch_t;

   mch_t m [2][4];

   function automatic mch_t ch_next(input mch_t c, input logic raw, input logic rep_en);
      mch_t n;
      logic nst;
      n   = c;
      nst = c.st;
      if (&c.hist[DB:1])       nst = 1'b1;
      else if (~|c.hist[DB:1]) nst = 1'b0;
      n.strobe = 1'b0;
      if (!c.st && nst) begin
         n.strobe = 1'b1;
         n.age    = 0;
      end else if (c.st && nst) begin
         n.age = c.age + 1;
         if (rep_en && (n.age == DLY || (n.age > DLY && ((n.age - DLY) % PER) == 0)))
            n.strobe = 1'b1;
      end else begin
         n.age = 0;
      end
      n.st   = nst;
      n.hist = {c.hist[6:0], raw};
      return n;
   endfunction

   always @(posedge clk or negedge clr) begin
      for (int i = 0; i < 2; i++)
         for (int c = 0; c < 4; c++)
            if (!clr) m[i][c] <= '0;
            else      m[i][c] <= ch_next(m[i][c], keys[c], (i == 0));
   end

   function automatic logic [3:0] m_str(input int i);
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = m[i][c].strobe;
      return r;
   endfunction

   function automatic logic [3:0] m_held(input int i);
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = m[i][c].st;
      return r;
   endfunction

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      check("strobe_a", {28'd0, str_a},  {28'd0, m_str(0)});
      check("held_a",   {28'd0, held_a}, {28'd0, m_held(0)});
      check("any_a",    {31'd0, any_a},  {31'd0, |m_str(0)});
      check("strobe_b", {28'd0, str_b},  {28'd0, m_str(1)});
      check("held_b",   {28'd0, held_b}, {28'd0, m_held(1)});
      check("any_b",    {31'd0, any_b},  {31'd0, |m_str(1)});
   end

   // ---------------- directed scenarios ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin : stim
      int cnt_a, cnt_b, cnt_m, first, second, third, last;
      int bounce [6] = '{1, 1, 2, 2, 3, 3};

      ticks(3);
      check("reset_strobes", {28'd0, str_a}, 32'd0);
      check("reset_held",    {28'd0, held_a}, 32'd0);
      check("reset_any",     {31'd0, any_a}, 32'd0);
      #2 clr = 1'b1;
      ticks(2);

      // Clean press on up, 5 sampled cycles, then release.
      up = 1'b1;
      ticks(5);
      check("s1_no_early_U", {31'd0, str_a[KEY_UP]}, 32'd0);
      up = 1'b0;
      tick();
      check("s1_U_pulse",     {31'd0, str_a[KEY_UP]}, 32'd1);
      check("s1_model_U",     {31'd0, m[0][KEY_UP].strobe}, 32'd1);
      check("s1_held_up",     {31'd0, held_a[KEY_UP]}, 32'd1);
      tick();
      check("s1_U_one_cycle", {31'd0, str_a[KEY_UP]}, 32'd0);
      ticks(3);
      check("s1_held_still",  {31'd0, held_a[KEY_UP]}, 32'd1);
      tick();
      check("s1_held_fall",   {31'd0, held_a[KEY_UP]}, 32'd0);
      ticks(10);

      // Bounce on right: runs of 1,1,2,2,3,3 cycles, then stable high.
      cnt_a = 0;
      for (int j = 0; j < 6; j++) begin
         right = (j % 2 == 0);
         for (int t = 0; t < bounce[j]; t++) begin
            tick();
            if (str_a[KEY_RIGHT]) cnt_a++;
         end
      end
      right = 1'b1;
      for (int t = 0; t < 5; t++) begin
         tick();
         if (str_a[KEY_RIGHT]) cnt_a++;
      end
      check("s2_no_bounce_R", cnt_a, 0);
      tick();
      check("s2_R_pulse",     {31'd0, str_a[KEY_RIGHT]}, 32'd1);
      right = 1'b0;
      cnt_a = 0;
      for (int t = 0; t < 12; t++) begin
         tick();
         if (str_a[KEY_RIGHT]) cnt_a++;
      end
      check("s2_no_release_R", cnt_a, 0);

      // Hold down for 30 sampled cycles: pulses at 6, 16, 19, ..., 34.
      cnt_a = 0; cnt_m = 0; first = 0; second = 0; third = 0; last = 0;
      down = 1'b1;
      for (int t = 1; t <= 45; t++) begin
         if (t == 31) down = 1'b0;
         tick();
         if (m[0][KEY_DOWN].strobe) cnt_m++;
         if (str_a[KEY_DOWN]) begin
            cnt_a++;
            if (cnt_a == 1) first = t;
            if (cnt_a == 2) second = t;
            if (cnt_a == 3) third = t;
            last = t;
         end
      end
      check("s3_D_count",       cnt_a,  8);
      check("s3_model_count",   cnt_m,  8);
      check("s3_D_first",       first,  6);
      check("s3_D_delay",       second, 16);
      check("s3_D_period",      third,  19);
      check("s3_D_last",        last,   34);

      // Hold right 40 cycles: release coincides with a due repeat and must win.
      cnt_a = 0; cnt_b = 0; last = 0;
      right = 1'b1;
      for (int t = 1; t <= 55; t++) begin
         if (t == 41) right = 1'b0;
         tick();
         if (str_a[KEY_RIGHT]) begin cnt_a++; last = t; end
         if (str_b[KEY_RIGHT]) cnt_b++;
      end
      check("s6_R_count_rep",   cnt_a, 11);
      check("s6_R_last_rep",    last,  43);
      check("s6_R_count_norep", cnt_b, 1);

      // left and up on the same edge.
      left = 1'b1; up = 1'b1;
      ticks(5);
      check("s4_any_early", {31'd0, any_a}, 32'd0);
      tick();
      check("s4_strobes",   {28'd0, str_a}, 32'h9);
      check("s4_model_L",   {31'd0, m[0][KEY_LEFT].strobe}, 32'd1);
      check("s4_any",       {31'd0, any_a}, 32'd1);
      tick();
      check("s4_any_once",  {31'd0, any_a}, 32'd0);
      left = 1'b0; up = 1'b0;
      ticks(12);

      // Reset mid-repeat with down held, then restart as a fresh press.
      down = 1'b1;
      ticks(20);
      check("s5_held_before", {31'd0, held_a[KEY_DOWN]}, 32'd1);
      #2 clr = 1'b0;
      #1;
      check("s5_clr_strobes", {28'd0, str_a},  32'd0);
      check("s5_clr_held",    {28'd0, held_a}, 32'd0);
      check("s5_clr_any",     {31'd0, any_a},  32'd0);
      ticks(2);
      #2 clr = 1'b1;
      cnt_a = 0; first = 0; second = 0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (str_a[KEY_DOWN]) begin
            cnt_a++;
            if (cnt_a == 1) first = t;
            if (cnt_a == 2) second = t;
         end
      end
      check("s5_D_first",  first,  6);
      check("s5_D_repeat", second, 16);
      check("s5_D_count",  cnt_a,  3);
      down = 1'b0;
      ticks(15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
